// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencer: command opcodes, FSM states and the
// opcode encodings used on the command interface.
package counter_ctrl_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_ENC_NOP  = 2'd0;
  localparam logic [OP_W-1:0] OP_ENC_LOAD = 2'd1;
  localparam logic [OP_W-1:0] OP_ENC_UP   = 2'd2;
  localparam logic [OP_W-1:0] OP_ENC_DOWN = 2'd3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = OP_ENC_NOP,
    OP_LOAD = OP_ENC_LOAD,
    OP_UP   = OP_ENC_UP,
    OP_DOWN = OP_ENC_DOWN
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/counter_core.sv
// Loadable up/down counter datapath.
// Ports:
//   clk, rst      - rising-edge clock, async active-high reset (count -> 0)
//   load          - load data_load this edge (wins over ce)
//   data_load     - value to load
//   ce            - count enable
//   up_down       - 1 = increment, 0 = decrement (modular)
//   count_out     - current count
//   max_count     - count_out is all ones
//   zero          - count_out is zero
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_load,
  input  logic             ce,
  input  logic             up_down,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
    end else if (load) begin
      count_out <= data_load;
    end else if (ce) begin
      if (up_down) count_out <= count_out + WIDTH'(1);
      else         count_out <= count_out - WIDTH'(1);
    end
  end

  assign max_count = (count_out == '1);
  assign zero      = (count_out == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer around counter_core: runs LOAD, COUNT-UP-N and
// COUNT-DOWN-N jobs, one at a time, with optional saturation and abort.
// Ports:
//   clk, rst          - rising-edge clock, async active-high reset
//   cmd_valid/ready   - command handshake (accept = valid & ready at an edge)
//   cmd_op            - 0=NOP 1=LOAD 2=UP 3=DOWN
//   cmd_data          - LOAD value
//   cmd_steps         - UP/DOWN step count
//   cfg_saturate      - sampled at accept; stop at max/zero instead of wrapping
//   abort             - ends a running UP/DOWN job
//   count_out         - counter value; max_count/zero decoded from it
//   busy              - job in progress
//   done              - one-cycle completion pulse
//   bound_hit/aborted - how the last job ended; held until the next accept
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cfg_saturate,
  input  logic              abort,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              bound_hit,
  output logic              aborted
);

  state_e            state, state_d;
  op_e               op_q;
  logic [WIDTH-1:0]  data_q;
  logic [STEP_W-1:0] remaining;
  logic              sat_q;

  logic accept;
  logic core_load, core_ce, core_up;
  logic set_bound, set_abort;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = cmd_valid & cmd_ready;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .data_load (data_q),
    .ce        (core_ce),
    .up_down   (core_up),
    .count_out (count_out),
    .max_count (max_count),
    .zero      (zero)
  );

  always_comb begin
    state_d   = state;
    core_load = 1'b0;
    core_ce   = 1'b0;
    core_up   = (op_q == OP_UP);
    set_bound = 1'b0;
    set_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_NOP:  state_d = S_DONE;
            OP_LOAD: state_d = S_LOAD;
            default: state_d = (cmd_steps == '0) ? S_DONE : S_RUN;
          endcase
        end
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_d   = S_DONE;
      end
      S_RUN: begin
        // Abort is checked before the bound so it wins when both coincide.
        if (abort) begin
          set_abort = 1'b1;
          state_d   = S_DONE;
        end else if (sat_q && (core_up ? max_count : zero)) begin
          set_bound = 1'b1;
          state_d   = S_DONE;
        end else begin
          core_ce = 1'b1;
          if (remaining == STEP_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      data_q    <= '0;
      remaining <= '0;
      sat_q     <= 1'b0;
      bound_hit <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q      <= op_e'(cmd_op);
        data_q    <= cmd_data;
        remaining <= cmd_steps;
        sat_q     <= cfg_saturate;
        bound_hit <= 1'b0;
        aborted   <= 1'b0;
      end else begin
        if (core_ce)   remaining <= remaining - STEP_W'(1);
        if (set_bound) bound_hit <= 1'b1;
        if (set_abort) aborted   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int W    = 4;
  localparam int SW   = 8;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cfg_saturate = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  count_out;
  logic          max_count, zero, busy, done, bound_hit, aborted;

  int tests = 0;
  int fails = 0;

  counter_seq_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_steps    (cmd_steps),
    .cfg_saturate (cfg_saturate),
    .abort        (abort),
    .count_out    (count_out),
    .max_count    (max_count),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .bound_hit    (bound_hit),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op, data, steps, sat, ab_at;
    int e_cnt, e_bnd, e_ab, e_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job-level reference: final count, flags, and edges from accept to done.
  function automatic void model(input int c0, input int op, input int data,
                                input int steps, input int sat, input int ab_at,
                                output int cnt, output int bnd, output int ab,
                                output int lat);
    cnt = c0; bnd = 0; ab = 0; lat = 0;
    if (op == 1) begin
      cnt = data; lat = 1;
    end else if (op >= 2 && steps > 0) begin
      for (int k = 1; k <= steps; k++) begin
        lat = k;
        if (k == ab_at) begin ab = 1; break; end
        if (sat != 0 && ((op == 2 && cnt == MAXV) || (op == 3 && cnt == 0))) begin
          bnd = 1; break;
        end
        cnt = (op == 2) ? (cnt + 1) % (MAXV + 1) : (cnt + MAXV) % (MAXV + 1);
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input int op, input int data, input int steps, input int sat);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op = op[1:0];
    cmd_data = data[W-1:0];
    cmd_steps = steps[SW-1:0];
    cfg_saturate = sat[0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
  endtask

  // abort is raised for the ab_at-th cycle after accept (0 = never).
  task automatic run_job(input int op, input int data, input int steps,
                         input int sat, input int ab_at, output int lat);
    send(op, data, steps, sat);
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin lat = c; break; end
      abort = (c + 1 == ab_at);
      @(negedge clk);
    end
    abort = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    vec_t vecs[17];
    int lat, cur, m_cnt, m_bnd, m_ab, m_lat;
    int zeros, dones;
    int tr[4];

    vecs[0]  = '{1, 10,  0, 0, 0, 10, 0, 0,  1};
    vecs[1]  = '{2,  0,  3, 0, 0, 13, 0, 0,  3};
    vecs[2]  = '{2,  0,  5, 1, 0, 15, 1, 0,  3};
    vecs[3]  = '{3,  0,  0, 1, 0, 15, 0, 0,  0};
    vecs[4]  = '{2,  0,  2, 0, 0,  1, 0, 0,  2};
    vecs[5]  = '{3,  0,  3, 1, 0,  0, 1, 0,  2};
    vecs[6]  = '{3,  0,  1, 0, 0, 15, 0, 0,  1};
    vecs[7]  = '{1,  3,  0, 0, 1,  3, 0, 0,  1};
    vecs[8]  = '{2,  0,  4, 1, 4,  6, 0, 1,  4};
    vecs[9]  = '{2,  0, 15, 1, 0, 15, 1, 0, 10};
    vecs[10] = '{1,  0,  0, 0, 0,  0, 0, 0,  1};
    vecs[11] = '{2,  0, 16, 0, 0,  0, 0, 0, 16};
    vecs[12] = '{3,  0,  1, 1, 1,  0, 0, 1,  1};
    vecs[13] = '{0,  9,  9, 1, 0,  0, 0, 0,  0};
    vecs[14] = '{2,  0,  0, 1, 0,  0, 0, 0,  0};
    vecs[15] = '{1, 15,  0, 0, 0, 15, 0, 0,  1};
    vecs[16] = '{2,  0,  3, 1, 0, 15, 1, 0,  1};

    // Reset values, observed while rst is still high.
    #12;
    chk("rst_count", int'(count_out), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_flags", int'({bound_hit, aborted}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven jobs; each row starts from the count left by the previous.
    foreach (vecs[i]) begin
      run_job(vecs[i].op, vecs[i].data, vecs[i].steps, vecs[i].sat, vecs[i].ab_at, lat);
      chk($sformatf("tbl%0d_lat", i), lat, vecs[i].e_lat);
      chk($sformatf("tbl%0d_cnt", i), int'(count_out), vecs[i].e_cnt);
      chk($sformatf("tbl%0d_bnd", i), int'(bound_hit), vecs[i].e_bnd);
      chk($sformatf("tbl%0d_ab", i), int'(aborted), vecs[i].e_ab);
      chk($sformatf("tbl%0d_max", i), int'(max_count), int'(vecs[i].e_cnt == MAXV));
      chk($sformatf("tbl%0d_zero", i), int'(zero), int'(vecs[i].e_cnt == 0));
      chk($sformatf("tbl%0d_ready", i), int'(cmd_ready), 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_hold_bnd", i), int'(bound_hit), vecs[i].e_bnd);
      chk($sformatf("tbl%0d_idle_ready", i), int'(cmd_ready), 1);
    end

    // LOAD E then UP 3 wrapping: count trace E,F,0,1; zero for one cycle; one done.
    run_job(1, 14, 0, 0, 0, lat);
    @(negedge clk);
    send(2, 0, 3, 0);
    tr[0] = 14; tr[1] = 15; tr[2] = 0; tr[3] = 1;
    zeros = 0; dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) chk($sformatf("wrap_c%0d", c), int'(count_out), tr[c]);
      zeros += int'(zero);
      dones += int'(done);
      @(negedge clk);
    end
    chk("wrap_zero_cycles", zeros, 1);
    chk("wrap_done_pulses", dones, 1);
    chk("wrap_bnd", int'(bound_hit), 0);

    // NOP and UP 0: busy/done for exactly one cycle, count unchanged.
    send(0, 5, 0, 0);
    chk("nop_busy", int'(busy), 1);
    chk("nop_done", int'(done), 1);
    chk("nop_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("nop_busy_after", int'(busy), 0);
    chk("nop_done_after", int'(done), 0);
    send(2, 0, 0, 0);
    chk("up0_done", int'(done), 1);
    @(negedge clk);
    chk("up0_busy_after", int'(busy), 0);
    chk("up0_cnt", int'(count_out), 1);

    // LOAD 2, DOWN 5, abort in the second RUN cycle.
    run_job(1, 2, 0, 0, 0, lat);
    @(negedge clk);
    run_job(3, 0, 5, 0, 2, lat);
    chk("abort_lat", lat, 2);
    chk("abort_cnt", int'(count_out), 1);
    chk("abort_flag", int'(aborted), 1);
    chk("abort_bnd", int'(bound_hit), 0);
    @(negedge clk);
    chk("abort_hold_cnt", int'(count_out), 1);

    // Reset in the middle of a long DOWN job.
    run_job(1, 0, 0, 0, 0, lat);
    @(negedge clk);
    send(3, 0, 200, 0);
    repeat (5) @(negedge clk);
    chk("midrun_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_cnt", int'(count_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done_after", int'(done), 0);
    run_job(1, 7, 0, 0, 0, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_cnt", int'(count_out), 7);
    cur = 7;

    // Randomized jobs against the job-level model.
    for (int j = 0; j < 60; j++) begin
      int op, data, steps, sat, ab_at;
      op    = int'($urandom_range(0, 3));
      data  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : MAXV)
                                          : int'($urandom_range(0, MAXV));
      steps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                          : int'($urandom_range(0, 20));
      sat   = int'($urandom_range(0, 1));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(cur, op, data, steps, sat, ab_at, m_cnt, m_bnd, m_ab, m_lat);
      run_job(op, data, steps, sat, ab_at, lat);
      chk($sformatf("rnd%0d_lat", j), lat, m_lat);
      chk($sformatf("rnd%0d_cnt", j), int'(count_out), m_cnt);
      chk($sformatf("rnd%0d_bnd", j), int'(bound_hit), m_bnd);
      chk($sformatf("rnd%0d_ab", j), int'(aborted), m_ab);
      @(negedge clk);
      chk($sformatf("rnd%0d_hold", j), int'({bound_hit, aborted, busy}), (m_bnd << 2) | (m_ab << 1));
      cur = m_cnt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command-driven sequencer that owns a loadable up/down counter and runs LOAD, COUNT-UP-N and COUNT-DOWN-N jobs on it.
- Accepts one command at a time via a valid/ready handshake.
- Drives the counter's load/ce/up_down controls, tracks remaining steps and optionally saturates at the counter bounds.
- Reports completion with a one-cycle done pulse plus status flags.
- Sits between a register/bus front end and the counter datapath.

Parameters:
- WIDTH, 4: counter width in bits.
- STEP_W, 8: width of the step-count field; a single job runs at most 2^STEP_W-1 steps.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0=NOP, 1=LOAD, 2=UP, 3=DOWN.
- cmd_data  in  WIDTH  load value; used by LOAD only.
- cmd_steps  in  STEP_W  number of steps; used by UP/DOWN only.
- cfg_saturate  in  1  sampled at accept; 1 = stop at max/zero instead of wrapping.
- abort  in  1  terminates a running UP/DOWN job.
- count_out  out  WIDTH  current counter value.
- max_count  out  1  count_out == all ones.
- zero  out  1  count_out == 0.
- busy  out  1  a job is in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- bound_hit  out  1  last job stopped early at a bound; valid from done, held until the next accept.
- aborted  out  1  last job ended by abort; valid from done, held until the next accept.

Behaviour:
- Reset (async, any state): state=IDLE, count_out=0, done=0, busy=0, bound_hit=0, aborted=0, remaining=0. cmd_ready=1 in IDLE, including while rst is high.
- States and transitions:
  - IDLE: cmd_ready=1. Accept = cmd_valid & cmd_ready at a rising edge. At accept: latch op, data, steps and cfg_saturate; clear bound_hit and aborted.
  - From IDLE: NOP -> DONE. LOAD -> LOAD. UP/DOWN with steps==0 -> DONE. UP/DOWN with steps>0 -> RUN, remaining=steps.
  - LOAD: one cycle; the edge loads count_out<=data; -> DONE.
  - RUN: each edge does count +/-1 and remaining-1. Exit to DONE on the edge where remaining==1.
  - DONE: done=1, busy=1, cmd_ready=0 for exactly one cycle; -> IDLE.
- Latency:
  - Accept at edge T.
  - LOAD: count updated at T+1; done high in cycle T+1..T+2; cmd_ready again after T+2.
  - UP/DOWN N: steps occur at edges T+1..T+N; done high after T+N; next accept possible at T+N+2.
- Arithmetic: WIDTH-bit modular. With cfg_saturate=0, UP from all-ones wraps to 0 and DOWN from 0 wraps to all-ones.
- Saturation: with cfg_saturate=1, in RUN, if UP and max_count, or DOWN and zero:
  - no step is taken that edge;
  - bound_hit<=1;
  - -> DONE.
  - A job accepted while already at the bound finishes after one RUN cycle with count unchanged and bound_hit=1.
- Abort:
  - abort high in RUN at an edge: no step that edge, aborted<=1, -> DONE.
  - abort is ignored in IDLE, LOAD and DONE.
  - If abort and the saturation condition coincide, abort wins: aborted=1, bound_hit=0.
- Count ownership: count changes only through the sequencer; it holds in IDLE and DONE.
- max_count and zero are combinational from count_out.
- Reset mid-job: the job is discarded immediately, no done pulse, all outputs take reset values.
- cmd_valid while not ready: ignored. The sender holds it until accepted; cmd fields must be stable while valid & !ready.

Decomposition:
- Package counter_ctrl_pkg:
  - op_e {OP_NOP, OP_LOAD, OP_UP, OP_DOWN};
  - state_e {S_IDLE, S_LOAD, S_RUN, S_DONE};
  - constants for the op encodings.
- Sub-module counter_core (WIDTH): clk, rst, load, data_load, ce, up_down, count_out, max_count, zero.
  - Async active-high reset to 0; load has priority over ce.
  - The sequencer FSM instantiates it and drives its controls.

Test Plan:
- Reset then LOAD data=4'hA -> count_out=A at T+1, done pulse after T+1, max_count=0, zero=0, cmd_ready back after T+2.
- LOAD 4'hE, UP steps=3, cfg_saturate=0 -> count sequence F, 0, 1; done once; bound_hit=0; zero high exactly one cycle.
- LOAD 4'hD, UP steps=10, cfg_saturate=1 -> count D, E, F, then stop; bound_hit=1; done after 3 RUN cycles; count_out holds F.
- LOAD 2, DOWN steps=5 with abort pulsed during the 2nd RUN cycle -> count 1 then hold; aborted=1; done next cycle; count_out=1.
- UP steps=0 and NOP -> done after one cycle, count unchanged, busy high for exactly one cycle.
- DOWN steps=200 from 0 with rst asserted mid-RUN -> count_out=0, busy=0 and no done immediately; cmd_ready=1; next LOAD 7 completes normally.
